// File: rtl/frame_loader_bram0_if.sv
// Pixel stream and BRAM0 port-0 bundle for the Sobel frame loader.
// The master drives the pixel stream; the slave (loader) drives s_ready and the BRAM port.
interface frame_loader_bram0_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 16
);
  logic                  s_valid;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_sof;
  logic                  s_eof;
  logic                  s_ready;
  logic                  b0_ce0;
  logic                  b0_we0;
  logic [ADDR_WIDTH-1:0] b0_addr0;
  logic [DATA_WIDTH-1:0] b0_d0;

  modport master (
    output s_valid, s_data, s_sof, s_eof,
    input  s_ready, b0_ce0, b0_we0, b0_addr0, b0_d0
  );

  modport slave (
    input  s_valid, s_data, s_sof, s_eof,
    output s_ready, b0_ce0, b0_we0, b0_addr0, b0_d0
  );
endinterface

// File: rtl/frame_loader_bram0.sv
// Loads one raster frame into BRAM0 port 0, then hands it to the downstream Sobel FSM.
// Optional early end-of-frame on s_eof when FRAME_LOADER_EOF_EN is defined.
module frame_loader_bram0 #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned IMAGE_WIDTH  = 100,
  parameter int unsigned IMAGE_HEIGHT = 100
) (
  input  logic                  clk,
  input  logic                  rst,
  frame_loader_bram0_if.slave   bus,
  input  logic                  i_mode,
  output logic                  o_en,
  output logic [ADDR_WIDTH-1:0] o_num_cnt,
  output logic                  o_run,
  input  logic                  i_fsm_idle,
  input  logic                  i_fsm_done,
  output logic                  o_busy,
  output logic                  o_err
);

  localparam int unsigned FramePixInt = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam logic [ADDR_WIDTH:0] FramePix = (ADDR_WIDTH + 1)'(FramePixInt);
  localparam logic [ADDR_WIDTH:0] CntOne   = (ADDR_WIDTH + 1)'(1);

  typedef enum logic [1:0] {StIdle, StLoad, StHandoff, StWaitDone} state_e;

  state_e                r_state;
  logic [ADDR_WIDTH:0]   r_pix_cnt;
  logic                  r_ready;
  logic                  r_wr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_en;
  logic [ADDR_WIDTH-1:0] r_num_cnt;
  logic                  r_run;
  logic                  r_busy;
  logic                  r_err;

  state_e                w_state_next;
  logic [ADDR_WIDTH:0]   w_cnt_next;
  logic                  w_accept;
  logic                  w_write;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic                  w_en_next;
  logic [ADDR_WIDTH-1:0] w_num_next;
  logic                  w_run_next;
  logic                  w_err_next;
  logic                  w_eof_hit;
  logic                  w_frame_end;

`ifdef FRAME_LOADER_EOF_EN
  assign w_eof_hit = bus.s_eof;
`else
  logic w_unused_eof;
  assign w_unused_eof = bus.s_eof;
  assign w_eof_hit    = 1'b0;
`endif

  assign w_accept = bus.s_valid && r_ready;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_pix_cnt;
    w_write      = 1'b0;
    w_wr_addr    = r_pix_cnt[ADDR_WIDTH-1:0];
    w_en_next    = 1'b0;
    w_num_next   = r_num_cnt;
    w_run_next   = r_run;
    w_err_next   = r_err;

    unique case (r_state)
      StIdle: begin
        // Beats before SOF are accepted but discarded.
        if (w_accept && bus.s_sof) begin
          w_write    = 1'b1;
          w_wr_addr  = '0;
          w_cnt_next = CntOne;
          w_run_next = i_mode;
        end
      end
      StLoad: begin
        if (w_accept) begin
          w_write = 1'b1;
          if (bus.s_sof) begin
            w_wr_addr  = '0;
            w_cnt_next = CntOne;
            w_run_next = i_mode;
            w_err_next = 1'b1;
          end else begin
            w_cnt_next = r_pix_cnt + CntOne;
          end
        end
      end
      StHandoff: begin
        if (i_fsm_idle) begin
          w_en_next    = 1'b1;
          w_state_next = StWaitDone;
        end
      end
      StWaitDone: begin
        if (i_fsm_done) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase

    w_frame_end = w_write && ((w_cnt_next == FramePix) || w_eof_hit);

    if (w_frame_end) begin
      w_state_next = StHandoff;
      w_num_next   = w_cnt_next[ADDR_WIDTH-1:0];
`ifdef FRAME_LOADER_EOF_EN
      // A short frame cannot be filtered, so demote it to a plain move.
      if (w_run_next && (w_cnt_next < FramePix)) begin
        w_run_next = 1'b0;
        w_err_next = 1'b1;
      end
`endif
    end else if (w_write) begin
      w_state_next = StLoad;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_pix_cnt <= '0;
      r_ready   <= 1'b0;
      r_wr      <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_en      <= 1'b0;
      r_num_cnt <= '0;
      r_run     <= 1'b0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_pix_cnt <= w_cnt_next;
      r_ready   <= (w_state_next == StIdle) || (w_state_next == StLoad);
      r_wr      <= w_write;
      if (w_write) begin
        r_addr <= w_wr_addr;
        r_data <= bus.s_data;
      end
      r_en      <= w_en_next;
      r_num_cnt <= w_num_next;
      r_run     <= w_run_next;
      r_busy    <= (w_state_next != StIdle);
      r_err     <= w_err_next;
    end
  end

  assign bus.s_ready  = r_ready;
  assign bus.b0_ce0   = r_wr;
  assign bus.b0_we0   = r_wr;
  assign bus.b0_addr0 = r_addr;
  assign bus.b0_d0    = r_data;
  assign o_en         = r_en;
  assign o_num_cnt    = r_num_cnt;
  assign o_run        = r_run;
  assign o_busy       = r_busy;
  assign o_err        = r_err;

endmodule
